// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults, width helpers and the status bus type for param_fifo
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: modulo-DEPTH wrapping pointer, valid for non-power-of-two DEPTH
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (inc) ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/param_fifo.sv
// param_fifo: parametrised synchronous FIFO with count, thresholds and sticky errors.
// Define PARAM_FIFO_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  localparam int CW = cnt_w(DEPTH),
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  input  logic             clr_err,
  output logic             overflow,
  output logic             underflow
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop, ovf_q, udf_q;
  fifo_status_t status;
  assign status = '{
    full:         count == CW'(DEPTH),
    empty:        count == '0,
    almost_full:  count >= CW'(AF_LEVEL),
    almost_empty: count <= CW'(AE_LEVEL),
    overflow:     ovf_q,
    underflow:    udf_q
  };
  assign {full, empty, almost_full, almost_empty, overflow, underflow} = status;
  // a full FIFO never passes a push through, an empty one never bypasses a pop
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;
  fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (.clk(clk), .rst(rst), .inc(push), .ptr(wr_ptr));
  fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (.clk(clk), .rst(rst), .inc(pop),  .ptr(rd_ptr));
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (push && !pop) count <= count + 1'b1;
    else if (pop && !push) count <= count - 1'b1;
  // a fresh error wins over a same-cycle clear
  always_ff @(posedge clk)
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (wr_en && full) || (ovf_q && !clr_err);
      udf_q <= (rd_en && empty) || (udf_q && !clr_err);
    end
`ifdef PARAM_FIFO_FWFT_EN
  assign rd_data  = mem[rd_ptr];
  assign rd_valid = !empty;
`else
  always_ff @(posedge clk)
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) rd_data <= mem[rd_ptr];
    end
`endif
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: DEPTH=4 and DEPTH=5 FIFOs on shared stimulus, checked against queue models and a read scoreboard
module tb_param_fifo;
  import fifo_pkg::*;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rdd [2];
  logic [2:0] cnt [2];
  logic rdv [2], fl [2], em [2], af [2], ae [2], ov [2], un [2];
  int dep [2] = '{4, 5};
  logic [7:0] q [2][$];
  logic [7:0] sb_d [2][$];
  int sb_c [2][$];
  bit mov [2], mun [2];
  int cyc = 0, checks = 0, failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    param_fifo #(.WIDTH(8), .DEPTH(4 + g)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rdd[g]), .rd_valid(rdv[g]), .count(cnt[g]), .full(fl[g]), .empty(em[g]),
      .almost_full(af[g]), .almost_empty(ae[g]), .clr_err(clr_err),
      .overflow(ov[g]), .underflow(un[g])
    );
  end

  task automatic step(input bit we, input logic [7:0] wd, input bit re, input bit ce, input bit r);
    fifo_status_t ex, ac;
    @(negedge clk);
    rst = r; wr_en = we; wr_data = wd; rd_en = re; clr_err = ce;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        q[k].delete();
        mov[k] = 1'b0;
        mun[k] = 1'b0;
      end else begin
        bit f, e;
        f = q[k].size() == dep[k];
        e = q[k].size() == 0;
        mov[k] = (we && f) || (mov[k] && !ce);
        mun[k] = (re && e) || (mun[k] && !ce);
        if (re && !e) begin
`ifdef PARAM_FIFO_FWFT_EN
          void'(q[k].pop_front());
`else
          sb_d[k].push_back(q[k].pop_front());
          sb_c[k].push_back(cyc + 1);
`endif
        end
        if (we && !f) q[k].push_back(wd);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      ex = '{full: q[k].size() == dep[k], empty: q[k].size() == 0,
             almost_full: q[k].size() >= dep[k] - 1, almost_empty: q[k].size() <= 1,
             overflow: mov[k], underflow: mun[k]};
      ac = '{fl[k], em[k], af[k], ae[k], ov[k], un[k]};
      checks++;
      if (ac !== ex || cnt[k] !== 3'(q[k].size())) begin
        failures++;
        $display("FAIL status depth=%0d cyc=%0d got count=%0d flags=%b expected count=%0d flags=%b",
                 dep[k], cyc, cnt[k], ac, q[k].size(), ex);
      end
    end
  endtask

  // read monitor: compares every presented read against the scoreboard
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
`ifdef PARAM_FIFO_FWFT_EN
      if (!rst) begin
        checks++;
        if (rdv[k] !== (q[k].size() != 0)) begin
          failures++;
          $display("FAIL fwft_valid depth=%0d got %b expected %b", dep[k], rdv[k], q[k].size() != 0);
        end else if (rdv[k] && rdd[k] !== q[k][0]) begin
          failures++;
          $display("FAIL fwft_data depth=%0d got %h expected %h", dep[k], rdd[k], q[k][0]);
        end
      end
`else
      if (rdv[k] === 1'b1) begin
        checks++;
        if (sb_d[k].size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected depth=%0d cyc=%0d got data=%h expected no rd_valid", dep[k], cyc, rdd[k]);
        end else begin
          logic [7:0] d;
          int c;
          d = sb_d[k].pop_front();
          c = sb_c[k].pop_front();
          if (rdd[k] !== d || c != cyc) begin
            failures++;
            $display("FAIL rd_data depth=%0d got %h at cyc %0d expected %h at cyc %0d", dep[k], rdd[k], cyc, d, c);
          end
        end
      end else if (sb_c[k].size() != 0 && sb_c[k][0] <= cyc) begin
        checks++;
        failures++;
        $display("FAIL rd_missing depth=%0d cyc=%0d got rd_valid=%b expected data %h", dep[k], cyc, rdv[k], sb_d[k][0]);
        void'(sb_d[k].pop_front());
        void'(sb_c[k].pop_front());
      end
`endif
    end
  end

  initial begin
    logic [7:0] t [4];
    t = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (2) step(0, 0, 0, 0, 1);
    foreach (t[i]) step(1, t[i], 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);
    foreach (t[i]) step(1, t[i] + 8'h01, 0, 0, 0);
    step(1, 8'h55, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (5) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    repeat (2) step(1, 8'hC0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 8'(i + 1), 1, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0);
    foreach (t[i]) step(1, t[i] + 8'h10, 0, 0, 0);
    step(1, 8'hAA, 1, 0, 0);
    repeat (5) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(1, 8'hBB, 1, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 8'h7E, 0, 0, 0);
    step(1, 8'h01, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
           $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    repeat (3) step(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (sb_d[k].size() != 0) begin
        failures++;
        $display("FAIL rd_pending depth=%0d got %0d undelivered reads expected 0", dep[k], sb_d[k].size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
